// File: rtl/gray_seq_gen.sv
// Gray-code sequence generator with a valid/ready output handshake.
// Single-pass or continuous (wrapping) operation, with stop and start control.
module gray_seq_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_cont,
  input  logic             stop,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_gray,
  output logic [WIDTH-1:0] out_bin,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic             mode_cont_r;
  logic             stop_pending_r;
  logic             xfer_s;
  logic             last_s;
  logic [WIDTH-1:0] next_bin_s;
  logic [WIDTH-1:0] next_gray_s;

  function automatic logic [WIDTH-1:0] gray_of(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Handshake decode and next beat values.
  always_comb begin
    xfer_s      = out_valid & out_ready;
    last_s      = (out_bin == {WIDTH{1'b1}});
    next_bin_s  = out_bin + {{(WIDTH-1){1'b0}}, 1'b1};
    next_gray_s = gray_of(next_bin_s);
  end

  // Sequencer state machine; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      mode_cont_r    <= 1'b0;
      stop_pending_r <= 1'b0;
      out_valid      <= 1'b0;
      out_gray       <= {WIDTH{1'b0}};
      out_bin        <= {WIDTH{1'b0}};
      busy           <= 1'b0;
      done           <= 1'b0;
      wrap           <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          wrap <= 1'b0;
          if (start) begin
            mode_cont_r <= mode_cont;
            out_bin     <= {WIDTH{1'b0}};
            out_gray    <= {WIDTH{1'b0}};
            out_valid   <= 1'b1;
            busy        <= 1'b1;
            state_r     <= RUN;
          end
        end
        RUN: begin
          wrap <= 1'b0;
          if (xfer_s) begin
            // A stop request beats both advancing and wrapping.
            if (stop_pending_r || stop) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state_r   <= DONE;
            end else if (last_s && !mode_cont_r) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state_r   <= DONE;
            end else if (last_s) begin
              wrap     <= 1'b1;
              out_bin  <= {WIDTH{1'b0}};
              out_gray <= {WIDTH{1'b0}};
            end else begin
              out_bin  <= next_bin_s;
              out_gray <= next_gray_s;
            end
          end else if (stop) begin
            stop_pending_r <= 1'b1;
          end
        end
        DONE: begin
          done           <= 1'b0;
          stop_pending_r <= 1'b0;
          state_r        <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          wrap      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_seq_gen.sv
// Directed bench for gray_seq_gen (WIDTH=4): single pass, backpressure,
// continuous wrap, stop handling, reset abort and start-while-busy.
module tb_gray_seq_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode_cont;
  logic       stop;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_gray;
  logic [3:0] out_bin;
  logic       busy;
  logic       done;
  logic       wrap;

  int total;
  int bad;
  int done_cnt;

  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_seq_gen #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode_cont (mode_cont),
    .stop      (stop),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_gray  (out_gray),
    .out_bin   (out_bin),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_seq(input logic mc);
    start = 1'b1;
    mode_cont = mc;
    tick();
    start = 1'b0;
    mode_cont = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    done_cnt = 0;
    rst = 1'b1;
    start = 1'b1;
    mode_cont = 1'b1;
    stop = 1'b0;
    out_ready = 1'b1;

    // Reset, with start asserted at the same time.
    tick();
    check("rst_valid", 16'(out_valid), 16'd0);
    check("rst_gray", 16'(out_gray), 16'd0);
    check("rst_bin", 16'(out_bin), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_wrap", 16'(wrap), 16'd0);
    rst = 1'b0;
    start = 1'b0;
    mode_cont = 1'b0;
    tick();
    check("idle_valid", 16'(out_valid), 16'd0);

    // Single pass.
    start_seq(1'b0);
    for (int i = 0; i < 16; i++) begin
      check("sp_valid", 16'(out_valid), 16'd1);
      check("sp_busy", 16'(busy), 16'd1);
      check("sp_gray", 16'(out_gray), 16'(gtab[i]));
      check("sp_bin", 16'(out_bin), 16'(i));
      tick();
    end
    check("sp_done", 16'(done), 16'd1);
    check("sp_done_valid", 16'(out_valid), 16'd0);
    check("sp_done_busy", 16'(busy), 16'd0);
    tick();
    check("sp_done_clear", 16'(done), 16'd0);
    check("sp_idle_valid", 16'(out_valid), 16'd0);

    // Backpressure at out_bin=3.
    start_seq(1'b0);
    repeat (3) tick();
    check("bp_bin3", 16'(out_bin), 16'd3);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_gray", 16'(out_gray), 16'h2);
      check("bp_hold_valid", 16'(out_valid), 16'd1);
      check("bp_hold_bin", 16'(out_bin), 16'd3);
    end
    out_ready = 1'b1;
    tick();
    for (int i = 4; i < 16; i++) begin
      check("bp_gray", 16'(out_gray), 16'(gtab[i]));
      check("bp_bin", 16'(out_bin), 16'(i));
      tick();
    end
    check("bp_done", 16'(done), 16'd1);
    tick();

    // Continuous mode, 40 beats, then stop with a same-cycle transfer.
    start_seq(1'b1);
    for (int k = 0; k < 40; k++) begin
      check("ct_gray", 16'(out_gray), 16'(gtab[k % 16]));
      check("ct_bin", 16'(out_bin), 16'(k % 16));
      check("ct_wrap", 16'(wrap), (k == 16 || k == 32) ? 16'd1 : 16'd0);
      check("ct_done", 16'(done), 16'd0);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("ct_stop_done", 16'(done), 16'd1);
    check("ct_stop_valid", 16'(out_valid), 16'd0);
    tick();

    // Stop under backpressure at out_bin=5.
    start_seq(1'b0);
    repeat (5) tick();
    check("sb_gray5", 16'(out_gray), 16'h7);
    out_ready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("sb_hold1", 16'(out_gray), 16'h7);
    tick();
    check("sb_hold2", 16'(out_gray), 16'h7);
    check("sb_hold_valid", 16'(out_valid), 16'd1);
    out_ready = 1'b1;
    tick();
    check("sb_done", 16'(done), 16'd1);
    check("sb_valid", 16'(out_valid), 16'd0);
    tick();
    check("sb_idle_valid", 16'(out_valid), 16'd0);

    // Stop wins over wrap on the all-ones beat in continuous mode.
    start_seq(1'b1);
    repeat (15) tick();
    check("sw_bin15", 16'(out_bin), 16'hF);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("sw_done", 16'(done), 16'd1);
    check("sw_wrap", 16'(wrap), 16'd0);
    check("sw_valid", 16'(out_valid), 16'd0);
    tick();

    // Reset mid-run at out_bin=9.
    start_seq(1'b0);
    repeat (9) tick();
    check("rr_bin9", 16'(out_bin), 16'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_valid", 16'(out_valid), 16'd0);
    check("rr_gray", 16'(out_gray), 16'd0);
    check("rr_done", 16'(done), 16'd0);
    tick();
    check("rr_done2", 16'(done), 16'd0);

    // Restart after reset; start pulses while busy must be ignored.
    start_seq(1'b0);
    check("rs_gray0", 16'(out_gray), 16'd0);
    check("rs_valid", 16'(out_valid), 16'd1);
    for (int i = 0; i < 16; i++) begin
      check("sib_gray", 16'(out_gray), 16'(gtab[i]));
      if (done) done_cnt++;
      start = (i % 4 == 1) ? 1'b1 : 1'b0;
      mode_cont = 1'b1;
      tick();
    end
    start = 1'b0;
    mode_cont = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("sib_done_count", 16'(done_cnt), 16'd1);
    check("sib_idle_valid", 16'(out_valid), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_seq_gen.md
GRAY_SEQ_GEN -- requirements
Module: gray_seq_gen

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, meaning the code width in bits (legal range 2..16).
REQ-002 SHALL provide port clk, input, 1, the single clock; all logic is rising-edge triggered.
REQ-003 SHALL provide port rst, input, 1, the reset: synchronous and active-high.
REQ-004 SHALL provide port start, input, 1, a request to begin a sequence; sampled only in IDLE.
REQ-005 SHALL provide port mode_cont, input, 1, where 1 means continuous (wrap) and 0 means single pass; latched when start is accepted.
REQ-006 SHALL provide port stop, input, 1, a request to end the sequence after the current beat.
REQ-007 SHALL provide port out_ready, input, 1, the consumer-ready signal.
REQ-008 SHALL provide port out_valid, output, 1, which is high when out_gray/out_bin hold a beat.
REQ-009 SHALL provide port out_gray, output, WIDTH, the current Gray code.
REQ-010 SHALL provide port out_bin, output, WIDTH, the binary index of the current beat.
REQ-011 SHALL provide port busy, output, 1, which is high in RUN.
REQ-012 SHALL provide port done, output, 1, a one-cycle pulse when a sequence ends.
REQ-013 SHALL provide port wrap, output, 1, a one-cycle pulse when continuous mode wraps from all-ones to 0.

Function
REQ-014 SHALL implement a state machine with the states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-015 SHALL, in IDLE with start=1, latch mode_cont, set cnt=0 and move to RUN at the next edge, so that out_valid=1 with out_gray=0 in the cycle after start.
REQ-016 SHALL ignore start in RUN and DONE.
REQ-017 SHALL drive out_gray = out_bin XOR (out_bin >> 1) at all times when out_valid=1.
REQ-018 SHALL count a transfer as out_valid and out_ready both high at a rising edge; on each transfer cnt SHALL increment modulo 2^WIDTH.
REQ-019 SHALL hold out_valid, out_gray and out_bin stable while out_valid=1 and out_ready=0; out_valid SHALL never drop without a transfer, except on rst.
REQ-020 SHALL, on a transfer of the all-ones beat with mode_cont latched at 0, move to DONE; out_valid=0 from the next cycle.
REQ-021 SHALL, on a transfer of the all-ones beat with mode_cont latched at 1, pulse wrap for one cycle, set cnt=0 and remain in RUN with no idle cycle.
REQ-022 SHALL set a stop_pending flag when stop=1 in RUN; on the next transfer (including a transfer in the same cycle as stop) the block SHALL move to DONE instead of advancing.
REQ-023 SHALL give stop priority over wrap when both apply on the same all-ones transfer: DONE, with wrap=0.
REQ-024 SHALL, in DONE, assert done=1 for exactly one cycle with out_valid=0 and busy=0, then return to IDLE, clearing stop_pending.
REQ-025 SHALL produce consecutive transferred out_gray values that differ in exactly one bit, including at the all-ones to 0 wrap.
REQ-026 SHALL sustain a throughput of one beat per cycle when out_ready is held at 1.

Reset
REQ-027 SHALL, when rst=1 at a rising edge, go to IDLE with out_valid=0, out_gray=0, out_bin=0, busy=0, done=0, wrap=0 and stop_pending=0, with mode_cont latched at 0.
REQ-028 SHALL abort a sequence when rst is applied mid-RUN, with the pending beat dropped and no done pulse; rst SHALL take priority over start in the same cycle.

Verification
REQ-029 SHALL verify the single pass: WIDTH=4, start=1 for one cycle, mode_cont=0, out_ready=1 -> 16 beats, out_gray = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then done=1 for one cycle, then IDLE.
REQ-030 SHALL verify backpressure: out_ready=0 for 5 cycles at out_bin=3 -> out_gray held at 0010 for 5 cycles with out_valid=1, then the sequence resumes at 0110 with no beat lost or repeated.
REQ-031 SHALL verify continuous mode: mode_cont=1, out_ready=1 for 40 cycles -> wrap pulses after the 16th and 32nd beats, beat 17 is 0000, and done never asserts.
REQ-032 SHALL verify stop with backpressure: stop=1 at out_bin=5 while out_ready=0, then out_ready=1 -> beat 5 (0111) transfers, DONE follows, and 0101 never appears.
REQ-033 SHALL verify reset mid-run: rst=1 at out_bin=9 -> next cycle out_valid=0 and out_gray=0000 with no done; a later start restarts from 0000.
REQ-034 SHALL verify that start is ignored while busy: start pulses in RUN -> sequence unaffected, with exactly one done pulse at the end.
